// File: rtl/ddr_sdram_local_test_master_if.sv
// Local-side request/response bundle between the self-test master and the DDR SDRAM controller.
interface ddr_sdram_local_test_master_if #(
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned ROW_BITS  = 13,
  parameter int unsigned BANK_BITS = 2,
  parameter int unsigned COL_BITS  = 9
);
  logic                   local_init_done;
  logic                   local_ready;
  logic                   local_rdata_valid;
  logic [DATA_BITS-1:0]   local_rdata;
  logic                   local_write_req;
  logic                   local_read_req;
  logic                   local_burstbegin;
  logic [1:0]             local_size;
  logic                   local_cs_addr;
  logic [ROW_BITS-1:0]    local_row_addr;
  logic [BANK_BITS-1:0]   local_bank_addr;
  logic [COL_BITS-2:0]    local_col_addr;
  logic [DATA_BITS-1:0]   local_wdata;
  logic [DATA_BITS/8-1:0] local_be;
  logic                   local_autopch_req;

  modport master (
    input  local_init_done, local_ready, local_rdata_valid, local_rdata,
    output local_write_req, local_read_req, local_burstbegin, local_size, local_cs_addr,
           local_row_addr, local_bank_addr, local_col_addr, local_wdata, local_be,
           local_autopch_req
  );

  modport slave (
    output local_init_done, local_ready, local_rdata_valid, local_rdata,
    input  local_write_req, local_read_req, local_burstbegin, local_size, local_cs_addr,
           local_row_addr, local_bank_addr, local_col_addr, local_wdata, local_be,
           local_autopch_req
  );
endinterface

// File: rtl/ddr_sdram_local_test_master.sv
// Memory self-test master: writes an address-derived pattern over NUM_WORDS local words,
// reads them back with bounded outstanding reads and reports pass/fail and the first bad address.
module ddr_sdram_local_test_master #(
  parameter  int unsigned DATA_BITS = 32,
  parameter  int unsigned ROW_BITS  = 13,
  parameter  int unsigned BANK_BITS = 2,
  parameter  int unsigned COL_BITS  = 9,
  parameter  int unsigned NUM_WORDS = 1024,
  parameter  int unsigned BURST     = 2,
  parameter  int unsigned MAX_OUTST = 8,
  localparam int unsigned ADDR_BITS = ROW_BITS + BANK_BITS + COL_BITS - 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  ddr_sdram_local_test_master_if.master lif,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          err_count,
  output logic [ADDR_BITS-1:0] first_err_addr
);

  localparam int unsigned CNT_BITS = ADDR_BITS + 1;
  localparam int unsigned OUT_BITS = $clog2(MAX_OUTST + BURST + 1);
  localparam int unsigned CHUNKS   = DATA_BITS / 32;
  localparam int unsigned BE_BITS  = DATA_BITS / 8;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_BITS-1:0]   waddr_q, waddr_d;
  logic [CNT_BITS-1:0]   raddr_q, raddr_d;
  logic [CNT_BITS-1:0]   caddr_q, caddr_d;
  logic [OUT_BITS-1:0]   outst_q, outst_d;
  logic [15:0]           err_q, err_d;
  logic [ADDR_BITS-1:0]  first_q, first_d;
  logic                  abort_q, abort_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  busy_q, busy_d;
  logic                  wr_req_q, wr_req_d;
  logic                  rd_req_q, rd_req_d;
  logic                  bb_q, bb_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [DATA_BITS-1:0]  wdata_q, wdata_d;
  logic [BE_BITS-1:0]    be_q, be_d;

  logic wr_acc, rd_acc, ret, mismatch, store_first;

  // pat(a) = {a[15:0], ~a[15:0]} repeated across the data word
  function automatic logic [DATA_BITS-1:0] pat(input logic [CNT_BITS-1:0] a);
    logic [15:0]          a16;
    logic [DATA_BITS-1:0] r;
    a16 = 16'(a);
    r   = '0;
    for (int i = 0; i < CHUNKS; i++) r[i*32 +: 32] = {a16, ~a16};
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    raddr_d     = raddr_q;
    caddr_d     = caddr_q;
    outst_d     = outst_q;
    err_d       = err_q;
    first_d     = first_q;
    abort_d     = abort_q;
    done_d      = done_q;
    pass_d      = pass_q;
    mismatch    = 1'b0;
    store_first = 1'b0;
    ret         = 1'b0;
    wr_acc      = wr_req_q && lif.local_ready;
    rd_acc      = rd_req_q && lif.local_ready;

    unique case (state_q)
      S_IDLE: begin
        if (start && lif.local_init_done) begin
          state_d = S_WRITE;
          waddr_d = '0;
          raddr_d = '0;
          caddr_d = '0;
          outst_d = '0;
          err_d   = '0;
          first_d = '0;
          abort_d = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      S_WRITE: begin
        if (wr_acc) begin
          waddr_d = waddr_q + CNT_BITS'(1);
          if (waddr_d == CNT_BITS'(NUM_WORDS)) state_d = S_READ;
        end
      end
      S_READ: begin
        if (rd_acc) begin
          raddr_d = raddr_q + CNT_BITS'(BURST);
          outst_d = outst_q + OUT_BITS'(BURST);
          if (raddr_d == CNT_BITS'(NUM_WORDS)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (outst_q == '0) state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        pass_d  = (err_q == '0) && !abort_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Read-data check; a return with nothing outstanding is an error that is not attributed to an address
    if ((state_q == S_READ || state_q == S_DRAIN) && lif.local_rdata_valid) begin
      if (outst_q == '0) begin
        mismatch = 1'b1;
        abort_d  = 1'b1;
      end else begin
        ret         = 1'b1;
        mismatch    = (lif.local_rdata != pat(caddr_q));
        store_first = mismatch;
        caddr_d     = caddr_q + CNT_BITS'(1);
      end
    end
    if (ret) outst_d = outst_d - OUT_BITS'(1);
    if (mismatch && err_q != 16'hFFFF) err_d = err_q + 16'd1;
    if (store_first && err_q == '0) first_d = caddr_q[ADDR_BITS-1:0];

    // Losing calibration aborts the test immediately
    if ((state_q == S_WRITE || state_q == S_READ || state_q == S_DRAIN) && !lif.local_init_done) begin
      state_d = S_DONE;
      abort_d = 1'b1;
    end

    busy_d   = (state_d == S_WRITE) || (state_d == S_READ) || (state_d == S_DRAIN);
    wr_req_d = (state_d == S_WRITE);
    rd_req_d = (state_d == S_READ) && (32'(outst_d) + BURST <= MAX_OUTST);
    bb_d     = wr_req_d ? ((BURST == 1) || !waddr_d[0]) : rd_req_d;
    addr_d   = '0;
    wdata_d  = '0;
    if (wr_req_d) begin
      addr_d  = waddr_d[ADDR_BITS-1:0] & ~ADDR_BITS'(BURST - 1);
      wdata_d = pat(waddr_d);
    end else if (rd_req_d) begin
      addr_d  = raddr_d[ADDR_BITS-1:0];
    end
    be_d = '1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      waddr_q  <= '0;
      raddr_q  <= '0;
      caddr_q  <= '0;
      outst_q  <= '0;
      err_q    <= '0;
      first_q  <= '0;
      abort_q  <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      busy_q   <= 1'b0;
      wr_req_q <= 1'b0;
      rd_req_q <= 1'b0;
      bb_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
    end else begin
      state_q  <= state_d;
      waddr_q  <= waddr_d;
      raddr_q  <= raddr_d;
      caddr_q  <= caddr_d;
      outst_q  <= outst_d;
      err_q    <= err_d;
      first_q  <= first_d;
      abort_q  <= abort_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      busy_q   <= busy_d;
      wr_req_q <= wr_req_d;
      rd_req_q <= rd_req_d;
      bb_q     <= bb_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
    end
  end

  assign lif.local_write_req   = wr_req_q;
  assign lif.local_read_req    = rd_req_q;
  assign lif.local_burstbegin  = bb_q;
  assign lif.local_size        = 2'(BURST);
  assign lif.local_cs_addr     = 1'b0;
  assign lif.local_col_addr    = addr_q[COL_BITS-2:0];
  assign lif.local_bank_addr   = addr_q[COL_BITS-1 +: BANK_BITS];
  assign lif.local_row_addr    = addr_q[COL_BITS-1+BANK_BITS +: ROW_BITS];
  assign lif.local_wdata       = wdata_q;
  assign lif.local_be          = be_q;
  assign lif.local_autopch_req = 1'b0;

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;

endmodule

// File: tb/tb_ddr_sdram_local_test_master.sv
// Directed bench: reactive local-interface slave with a write/read-address scoreboard,
// plus end-of-test status checks.
module tb_ddr_sdram_local_test_master;
  localparam int unsigned DATA_BITS = 32;
  localparam int unsigned ROW_BITS  = 13;
  localparam int unsigned BANK_BITS = 2;
  localparam int unsigned COL_BITS  = 9;
  localparam int unsigned ADDR_BITS = ROW_BITS + BANK_BITS + COL_BITS - 1;

  logic clk = 1'b0;
  logic reset, start;
  logic busy, done, pass;
  logic [15:0] err_count;
  logic [ADDR_BITS-1:0] first_err_addr;

  ddr_sdram_local_test_master_if #(.DATA_BITS(DATA_BITS), .ROW_BITS(ROW_BITS),
    .BANK_BITS(BANK_BITS), .COL_BITS(COL_BITS)) lif ();

  ddr_sdram_local_test_master #(.DATA_BITS(DATA_BITS), .ROW_BITS(ROW_BITS), .BANK_BITS(BANK_BITS),
    .COL_BITS(COL_BITS), .NUM_WORDS(8), .BURST(2), .MAX_OUTST(8)) u_dut (
    .clk(clk), .reset(reset), .start(start), .lif(lif.master), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] tpat(input int a);
    logic [15:0] v;
    v = a[15:0];
    return {v, ~v};
  endfunction

  typedef struct {int due; int addr;} ret_t;

  logic [31:0] mem [0:7];
  ret_t rq[$];
  int   exp_w[$];
  int   exp_r[$];
  int   ready_mode = 0, lat = 4, corrupt = -1;
  int   cyc = 0, last_due = 0, outst_tb = 0, rd_reqs = 0;
  logic hold_pending = 1'b0;
  logic [ADDR_BITS-1:0] hold_addr;
  logic [31:0] hold_data;
  logic init_done = 1'b1;

  assign lif.local_init_done = init_done;

  // Slave: decides ready for the coming edge, logs accepted beats, returns read data in order
  always @(negedge clk) begin
    logic r;
    logic [ADDR_BITS-1:0] a;
    int e, d0;
    logic [31:0] d;
    cyc++;
    a = {lif.local_row_addr, lif.local_bank_addr, lif.local_col_addr};
    if (reset) begin
      rq.delete();
      outst_tb = 0;
      hold_pending = 1'b0;
      lif.local_ready = 1'b0;
      lif.local_rdata_valid = 1'b0;
      lif.local_rdata = '0;
    end else begin
      r = (ready_mode == 0) ? 1'b1 : 1'(cyc % 2);
      if (hold_pending && lif.local_write_req) begin
        check("write_hold_addr", 64'(a), 64'(hold_addr));
        check("write_hold_data", 64'(lif.local_wdata), 64'(hold_data));
      end
      hold_pending = lif.local_write_req && !r;
      hold_addr = a;
      hold_data = lif.local_wdata;
      if (lif.local_read_req) check("outst_limit", 64'(outst_tb <= 6), 64'(1));
      if (lif.local_write_req && r) begin
        if (exp_w.size() == 0) check("unexpected_write", 64'(1), 64'(0));
        else begin
          e = exp_w.pop_front();
          check("write_group_addr", 64'(a), 64'(e & ~1));
          check("write_burstbegin", 64'(lif.local_burstbegin), 64'(e % 2 == 0));
          check("write_data", 64'(lif.local_wdata), 64'(tpat(e)));
        end
        mem[(int'(a) + (lif.local_burstbegin ? 0 : 1)) & 7] = lif.local_wdata;
      end
      if (lif.local_read_req && r) begin
        if (exp_r.size() == 0) check("unexpected_read", 64'(1), 64'(0));
        else check("read_addr", 64'(a), 64'(exp_r.pop_front()));
        d0 = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        rq.push_back('{due: d0, addr: int'(a)});
        rq.push_back('{due: d0 + 1, addr: int'(a) + 1});
        last_due = d0 + 1;
        outst_tb += 2;
        rd_reqs++;
      end
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        d = mem[rq[0].addr & 7];
        if (rq[0].addr == corrupt) d[0] = ~d[0];
        lif.local_rdata = d;
        lif.local_rdata_valid = 1'b1;
        void'(rq.pop_front());
        outst_tb--;
      end else begin
        lif.local_rdata_valid = 1'b0;
      end
      lif.local_ready = r;
    end
  end

  task automatic load_expect();
    exp_w.delete();
    exp_r.delete();
    for (int i = 0; i < 8; i++) exp_w.push_back(i);
    for (int i = 0; i < 8; i += 2) exp_r.push_back(i);
    rd_reqs = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("done_reached", 64'(done), 64'(1));
  endtask

  task automatic run_test(input int mode, input int latency, input int bad);
    ready_mode = mode;
    lat = latency;
    corrupt = bad;
    load_expect();
    pulse_start();
    wait_done();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_pass", 64'(pass), 64'(0));
    check("rst_write_req", 64'(lif.local_write_req), 64'(0));
    check("rst_read_req", 64'(lif.local_read_req), 64'(0));
    check("rst_size", 64'(lif.local_size), 64'(2));
    check("rst_be", 64'(lif.local_be), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    // 1: ideal slave, plus a start pulse while busy that must be ignored
    ready_mode = 0; lat = 4; corrupt = -1;
    load_expect();
    pulse_start();
    repeat (2) @(negedge clk);
    check("t1_busy", 64'(busy), 64'(1));
    pulse_start();
    wait_done();
    check("t1_pass", 64'(pass), 64'(1));
    check("t1_err", 64'(err_count), 64'(0));
    check("t1_rd_reqs", 64'(rd_reqs), 64'(4));
    check("t1_writes_left", 64'(exp_w.size()), 64'(0));
    check("t1_mem0", 64'(mem[0]), 64'(32'h0000FFFF));
    check("t1_mem5", 64'(mem[5]), 64'(32'h0005FFFA));

    // 2: ready toggling; memory image must match pattern
    for (int i = 0; i < 8; i++) mem[i] = '0;
    run_test(1, 4, -1);
    check("t2_pass", 64'(pass), 64'(1));
    for (int i = 0; i < 8; i++) check("t2_mem", 64'(mem[i]), 64'(tpat(i)));

    // 3: word 3 corrupted on read-back
    run_test(0, 4, 3);
    check("t3_err", 64'(err_count), 64'(1));
    check("t3_first", 64'(first_err_addr), 64'(3));
    check("t3_pass", 64'(pass), 64'(0));

    // 4: long read latency bounds outstanding reads
    run_test(0, 20, -1);
    check("t4_pass", 64'(pass), 64'(1));
    check("t4_err", 64'(err_count), 64'(0));
    check("t4_rd_reqs", 64'(rd_reqs), 64'(4));

    // 5: calibration lost mid-write
    ready_mode = 0; lat = 4; corrupt = -1;
    load_expect();
    pulse_start();
    repeat (2) @(negedge clk);
    init_done = 1'b0;
    @(negedge clk);
    check("t5_req_drop", 64'(lif.local_write_req), 64'(0));
    wait_done();
    check("t5_pass", 64'(pass), 64'(0));
    exp_w.delete();
    exp_r.delete();
    pulse_start();
    @(negedge clk);
    check("t5_start_ignored_busy", 64'(busy), 64'(0));
    check("t5_done_sticky", 64'(done), 64'(1));
    init_done = 1'b1;
    @(negedge clk);

    // 6: reset during read phase, then a clean rerun
    ready_mode = 0; lat = 20; corrupt = -1;
    load_expect();
    pulse_start();
    n = 0;
    while (lif.local_read_req !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6_read_seen", 64'(lif.local_read_req), 64'(1));
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t6_write_req", 64'(lif.local_write_req), 64'(0));
    check("t6_read_req", 64'(lif.local_read_req), 64'(0));
    check("t6_burstbegin", 64'(lif.local_burstbegin), 64'(0));
    check("t6_wdata", 64'(lif.local_wdata), 64'(0));
    check("t6_busy", 64'(busy), 64'(0));
    check("t6_done", 64'(done), 64'(0));
    check("t6_err", 64'(err_count), 64'(0));
    check("t6_size", 64'(lif.local_size), 64'(2));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_test(0, 4, -1);
    check("t6_pass", 64'(pass), 64'(1));
    check("t6_err_after", 64'(err_count), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
